// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause-22 MDIO responder with small PHY register file; MDIO_RESP_PREAMBLE_SUPPRESS_EN enables preamble suppression
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1622
) (
    input  logic        clk_i,
    input  logic        srst_n_i,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oen_o,
    input  logic        link_up_i,
    output logic        wr_stb_o,
    output logic [4:0]  wr_addr_o,
    output logic [15:0] wr_data_o
);

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0]  PRE_THRESH = 6'd1;
    localparam logic [15:0] BMSR_BASE  = 16'h7949;
`else
    localparam logic [5:0]  PRE_THRESH = 6'd32;
    localparam logic [15:0] BMSR_BASE  = 16'h7909;
`endif
    localparam logic [15:0] BMCR_RST = 16'h1140;

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_SKIP, S_TA, S_DATA
    } state_t;

    state_t      state;
    logic        mdc_s1, mdc_s2, mdc_q;
    logic        mdio_s1, mdio_s2;
    logic        mdc_rise;
    logic [5:0]  pre_cnt;
    logic [4:0]  bit_cnt;
    logic        op_msb;
    logic        is_read;
    logic [4:0]  phy_sh;
    logic [4:0]  reg_sh;
    logic [4:0]  reg_next;
    logic [15:0] shreg;
    logic [15:0] wr_word;
    logic [15:0] rd_word;
    logic [15:0] bmcr;
    logic [15:0] scratch [0:11];
    logic [3:0]  rd_idx;
    logic [3:0]  wr_idx;

    assign mdc_rise = mdc_s2 & ~mdc_q;
    assign reg_next = {reg_sh[3:0], mdio_s2};
    assign wr_word  = {shreg[14:0], mdio_s2};
    assign rd_idx   = reg_next[3:0] - 4'd4;
    assign wr_idx   = reg_sh[3:0] - 4'd4;

    // Word served by a read, evaluated on the last REGAD edge and then held in shreg
    always_comb begin
        rd_word = 16'h0000;
        case (reg_next)
            5'd0:    rd_word = bmcr;
            5'd1:    rd_word = BMSR_BASE | {13'b0, link_up_i, 2'b00};
            5'd2:    rd_word = PHY_ID1;
            5'd3:    rd_word = PHY_ID2;
            default: if (reg_next <= 5'd15) rd_word = scratch[rd_idx];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state      <= S_IDLE;
            mdc_s1     <= 1'b0;
            mdc_s2     <= 1'b0;
            mdc_q      <= 1'b0;
            mdio_s1    <= 1'b0;
            mdio_s2    <= 1'b0;
            pre_cnt    <= 6'd0;
            bit_cnt    <= 5'd0;
            op_msb     <= 1'b0;
            is_read    <= 1'b0;
            phy_sh     <= 5'd0;
            reg_sh     <= 5'd0;
            shreg      <= 16'h0000;
            mdio_o     <= 1'b0;
            mdio_oen_o <= 1'b1;
            wr_stb_o   <= 1'b0;
            wr_addr_o  <= 5'd0;
            wr_data_o  <= 16'h0000;
            bmcr       <= BMCR_RST;
            for (int i = 0; i < 12; i++) scratch[i] <= 16'h0000;
        end else begin
            mdc_s1   <= mdc_i;
            mdc_s2   <= mdc_s1;
            mdc_q    <= mdc_s2;
            mdio_s1  <= mdio_i;
            mdio_s2  <= mdio_s1;
            wr_stb_o <= 1'b0;
            if (mdc_rise) begin
                case (state)
                    S_IDLE: begin
                        if (mdio_s2) begin
                            if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
                        end else begin
                            if (pre_cnt >= PRE_THRESH) state <= S_ST;
                            pre_cnt <= 6'd0;
                        end
                    end
                    S_ST: begin
                        bit_cnt <= 5'd0;
                        state   <= mdio_s2 ? S_OP : S_IDLE;
                    end
                    S_OP: begin
                        op_msb  <= mdio_s2;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd1) begin
                            bit_cnt <= 5'd0;
                            case ({op_msb, mdio_s2})
                                2'b10:   begin is_read <= 1'b1; state <= S_PHYAD; end
                                2'b01:   begin is_read <= 1'b0; state <= S_PHYAD; end
                                default: state <= S_IDLE;
                            endcase
                        end
                    end
                    S_PHYAD: begin
                        phy_sh  <= {phy_sh[3:0], mdio_s2};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= 5'd0;
                            state   <= S_REGAD;
                        end
                    end
                    S_REGAD: begin
                        reg_sh  <= reg_next;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= 5'd0;
                            shreg   <= rd_word;
                            state   <= (phy_sh == PHY_ADDR) ? S_TA : S_SKIP;
                        end
                    end
                    S_SKIP: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd17) state <= S_IDLE;
                    end
                    S_TA: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd1) begin
                            bit_cnt <= 5'd0;
                            state   <= S_DATA;
                            if (is_read) begin
                                mdio_oen_o <= 1'b0;
                                mdio_o     <= 1'b0;
                            end
                        end
                    end
                    S_DATA: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (is_read) begin
                            if (bit_cnt == 5'd16) begin
                                // The release edge already belongs to the next frame's preamble
                                mdio_oen_o <= 1'b1;
                                mdio_o     <= 1'b0;
                                pre_cnt    <= {5'd0, mdio_s2};
                                state      <= S_IDLE;
                            end else begin
                                mdio_o <= shreg[15];
                                shreg  <= {shreg[14:0], 1'b0};
                            end
                        end else begin
                            shreg <= wr_word;
                            if (bit_cnt == 5'd15) begin
                                wr_stb_o  <= 1'b1;
                                wr_addr_o <= reg_sh;
                                wr_data_o <= wr_word;
                                state     <= S_IDLE;
                                case (reg_sh)
                                    5'd0: begin
                                        if (wr_word[15]) begin
                                            bmcr <= BMCR_RST;
                                            for (int i = 0; i < 12; i++) scratch[i] <= 16'h0000;
                                        end else begin
                                            bmcr <= {1'b0, wr_word[14:0]};
                                        end
                                    end
                                    default: if (reg_sh >= 5'd4 && reg_sh <= 5'd15) scratch[wr_idx] <= wr_word;
                                endcase
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
